mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Responder for the memory-stage data request and the fetch-stage instruction request; arbitrates both onto a single RAM port.
- Returns dhit/dload to the memory stage. dhit is what releases the MEM/WB latch enable and supplies its dload capture value.
- Returns ihit/iload to fetch.
- Data requests normally win, because the MEM-stage instruction is older. A starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while iREN is pending before one instruction grant is forced (1..15).
- WORD_W, 32, data/address width.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset
- iREN  in  1  fetch read request (level, held until ihit)
- iaddr  in  WORD_W  fetch address
- dREN  in  1  MEM-stage read request (level)
- dWEN  in  1  MEM-stage write request (level)
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  write data
- halt  in  1  processor halted; no new grants
- ihit  out  1  instruction access complete, one cycle
- iload  out  WORD_W  instruction word, valid with ihit
- dhit  out  1  data access complete, one cycle
- dload  out  WORD_W  read data, valid with dhit
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ram_ready  in  1  RAM access complete this cycle

Behaviour:
- States: IDLE, DACC, IACC. On clock with nRST=0, state goes to IDLE and starve_cnt, op_wr, req_addr and req_data go to 0.
- Reset values of outputs: ihit, dhit, ramREN and ramWEN are 0; iload, dload, ramaddr and ramstore are 0. Reset mid-access drops the access with no hit.
- Grant in IDLE, evaluated each cycle:
  - If halt=1, no grant.
  - Else if dREN|dWEN and not (iREN and starve_cnt==STARVE_LIMIT): latch daddr and dstore, set op_wr=dWEN, go DACC. starve_cnt increments (saturating at STARVE_LIMIT) if iREN=1; otherwise it clears.
  - Else if iREN: latch iaddr, go IACC, starve_cnt clears.
- dREN and dWEN both high: treated as a write.
- DACC drive:
  - ramaddr = latched address.
  - ramWEN = op_wr; ramREN = !op_wr.
  - ramstore = latched data.
- DACC completion: when ram_ready=1, dhit=1 in that same cycle, dload = ramload (0 for writes), and state goes to IDLE next cycle.
- DACC abort:
  - A read is aborted when dREN=0 before ram_ready (pipeline flush): go IDLE, no dhit.
  - A write never aborts once granted.
- IACC drive: ramREN=1, ramaddr = latched iaddr.
- IACC completion: when ram_ready=1, ihit=1 and iload = ramload in that cycle; go IDLE.
- IACC abort: when iREN=0, or iaddr differs from the latched address (redirect), go IDLE, no ihit. The new address is re-arbitrated from IDLE.
- Outside an active access, ihit, dhit, iload, dload, ramREN and ramWEN are 0, and ramaddr and ramstore are 0.
- ram_ready in IDLE is ignored.
- Minimum latency: request seen in IDLE cycle N, RAM strobes asserted from cycle N+1, hit in the first cycle with ram_ready=1 (earliest N+1). Back-to-back accesses therefore cost at least 2 cycles each.
- ihit and dhit are never asserted in the same cycle.
- halt asserted mid-access: the current access completes normally; only new grants are blocked.

Test Plan:
1. Data read alone: dREN=1, daddr=0x40; RAM returns 0xDEADBEEF with ram_ready on the 3rd DACC cycle.
   -> ramREN=1, ramaddr=0x40 from N+1; dhit=1 and dload=0xDEADBEEF for exactly one cycle; IDLE after.
2. Simultaneous iREN (iaddr=0x100) and dWEN (daddr=0x80, dstore=0x1234).
   -> Data granted first with ramWEN=1 and ramstore=0x1234; dhit follows; then IACC with ihit.
3. Starvation: iREN held and dREN re-asserted immediately after each dhit, STARVE_LIMIT=4.
   -> Exactly 4 dhits, then one ihit, then data resumes.
4. Flush abort: dREN read granted, dREN dropped before ram_ready.
   -> No dhit; ramREN=0 next cycle. A write granted with dWEN dropped still completes with dhit.
5. Redirect: IACC on iaddr=0x200, iaddr changes to 0x300 mid-access.
   -> No ihit for 0x200; re-grant with ramaddr=0x300; ihit with that data.
6. halt=1 with requests pending -> no new strobes.
   Reset (nRST=0) during DACC -> next cycle IDLE, all outputs 0, no dhit.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch stage, the memory stage, the
// shared RAM port and the arbiter that sits between them.
interface mem_arbiter_if #(parameter int WORD_W = 32);
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              halt;
   logic              ihit;
   logic [WORD_W-1:0] iload;
   logic              dhit;
   logic [WORD_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic              ram_ready;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ram_ready,
      output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ram_ready,
      input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win over instruction fetch, with a
// starvation counter that forces one fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int WORD_W       = 32
) (
   input logic          CLK,
   input logic          nRST,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t            state;
   logic [3:0]        starve_cnt;
   logic              op_wr;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_data;

   logic d_req, force_i, d_abort, i_abort, d_done, i_done;

   assign d_req   = bus.dREN | bus.dWEN;
   assign force_i = bus.iREN && (starve_cnt == LIMIT);
   // A granted write is committed; only a read may be flushed away.
   assign d_abort = !op_wr && !bus.dREN;
   assign i_abort = !bus.iREN || (bus.iaddr != req_addr);
   assign d_done  = nRST && (state == DACC) && bus.ram_ready && !d_abort;
   assign i_done  = nRST && (state == IACC) && bus.ram_ready && !i_abort;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         op_wr      <= 1'b0;
         req_addr   <= '0;
         req_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.halt) begin
                  if (d_req && !force_i) begin
                     req_addr <= bus.daddr;
                     req_data <= bus.dstore;
                     op_wr    <= bus.dWEN;
                     state    <= DACC;
                     if (bus.iREN)
                        starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
                     else
                        starve_cnt <= '0;
                  end else if (bus.iREN) begin
                     req_addr   <= bus.iaddr;
                     state      <= IACC;
                     starve_cnt <= '0;
                  end
               end
            end
            DACC:    if (d_abort || bus.ram_ready) state <= IDLE;
            IACC:    if (i_abort || bus.ram_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.ihit     = 1'b0;
      bus.iload    = '0;
      bus.dhit     = 1'b0;
      bus.dload    = '0;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      case (state)
         DACC: begin
            bus.ramaddr  = req_addr;
            bus.ramstore = req_data;
            bus.ramWEN   = op_wr;
            bus.ramREN   = !op_wr;
            bus.dhit     = d_done;
            bus.dload    = (d_done && !op_wr) ? bus.ramload : '0;
         end
         IACC: begin
            bus.ramaddr = req_addr;
            bus.ramREN  = 1'b1;
            bus.ihit    = i_done;
            bus.iload   = i_done ? bus.ramload : '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

   logic CLK = 1'b0;
   logic nRST;
   int   checks = 0;
   int   failures = 0;

   mem_arbiter_if #(.WORD_W(32)) bus ();

   mem_arbiter #(.STARVE_LIMIT(4), .WORD_W(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic idle_inputs();
      bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = 0; bus.dstore = 0; bus.halt = 0;
      bus.ramload = 0; bus.ram_ready = 0;
   endtask

   int d_before, d_after, i_cnt, both;
   logic seen_i;

   initial begin
      idle_inputs();
      nRST = 0;
      step(); step();
      #1;
      chk("rst_ramREN", 32'(bus.ramREN), 0);
      chk("rst_hits",   {30'd0, bus.ihit, bus.dhit}, 0);
      chk("rst_ramaddr", bus.ramaddr, 0);
      nRST = 1;

      // 1: data read, ready on third DACC cycle
      step();
      bus.dREN = 1; bus.daddr = 32'h40; #1;
      chk("t1_idle_ramREN", 32'(bus.ramREN), 0);
      step(); #1;
      chk("t1_ramREN", 32'(bus.ramREN), 1);
      chk("t1_ramaddr", bus.ramaddr, 32'h40);
      chk("t1_nohit1", 32'(bus.dhit), 0);
      step(); #1;
      chk("t1_nohit2", 32'(bus.dhit), 0);
      step();
      bus.ram_ready = 1; bus.ramload = 32'hDEADBEEF; #1;
      chk("t1_dhit", 32'(bus.dhit), 1);
      chk("t1_dload", bus.dload, 32'hDEADBEEF);
      step();
      bus.dREN = 0; bus.ram_ready = 0; #1;
      chk("t1_after_dhit", 32'(bus.dhit), 0);
      chk("t1_after_ramREN", 32'(bus.ramREN), 0);

      // 2: simultaneous fetch and write, data goes first
      bus.iREN = 1; bus.iaddr = 32'h100;
      bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
      bus.ram_ready = 1; bus.ramload = 32'h55;
      step(); #1;
      chk("t2_ramWEN", 32'(bus.ramWEN), 1);
      chk("t2_ramREN", 32'(bus.ramREN), 0);
      chk("t2_ramstore", bus.ramstore, 32'h1234);
      chk("t2_ramaddr", bus.ramaddr, 32'h80);
      chk("t2_dhit", 32'(bus.dhit), 1);
      chk("t2_dload_wr", bus.dload, 0);
      chk("t2_no_ihit", 32'(bus.ihit), 0);
      step();
      bus.dWEN = 0; #1;
      chk("t2_idle_ramREN", 32'(bus.ramREN), 0);
      step();
      bus.ramload = 32'h77; #1;
      chk("t2_iacc_addr", bus.ramaddr, 32'h100);
      chk("t2_ihit", 32'(bus.ihit), 1);
      chk("t2_iload", bus.iload, 32'h77);
      step();
      bus.iREN = 0; bus.ram_ready = 0;

      // 3: starvation, fetch forced after 4 data grants
      bus.iREN = 1; bus.iaddr = 32'h104;
      bus.dREN = 1; bus.daddr = 32'h44;
      bus.ram_ready = 1; bus.ramload = 32'h99;
      d_before = 0; d_after = 0; i_cnt = 0; both = 0; seen_i = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (bus.dhit && bus.ihit) both++;
         if (bus.ihit) begin seen_i = 1; i_cnt++; end
         if (bus.dhit) begin
            if (!seen_i) d_before++;
            else d_after++;
         end
         step();
      end
      chk("t3_d_before_i", d_before, 4);
      chk("t3_i_count", i_cnt, 1);
      chk("t3_d_after_i", d_after, 1);
      chk("t3_no_both", both, 0);
      idle_inputs();
      step();

      // 4: read flush, then a write that must complete anyway
      bus.dREN = 1; bus.daddr = 32'h48;
      step(); #1;
      chk("t4_rd_ramREN", 32'(bus.ramREN), 1);
      bus.dREN = 0; #1;
      chk("t4_flush_nohit", 32'(bus.dhit), 0);
      step(); #1;
      chk("t4_flush_ramREN", 32'(bus.ramREN), 0);
      bus.dWEN = 1; bus.daddr = 32'h4C; bus.dstore = 32'hAB;
      step(); #1;
      chk("t4_wr_ramWEN", 32'(bus.ramWEN), 1);
      bus.dWEN = 0;
      step(); #1;
      chk("t4_wr_held", 32'(bus.ramWEN), 1);
      bus.ram_ready = 1; #1;
      chk("t4_wr_dhit", 32'(bus.dhit), 1);
      step();
      bus.ram_ready = 0;

      // 5: fetch redirect mid-access
      bus.iREN = 1; bus.iaddr = 32'h200;
      step(); #1;
      chk("t5_addr200", bus.ramaddr, 32'h200);
      step();
      bus.iaddr = 32'h300; #1;
      chk("t5_redirect_noihit", 32'(bus.ihit), 0);
      step(); #1;
      chk("t5_idle_ramREN", 32'(bus.ramREN), 0);
      step();
      bus.ram_ready = 1; bus.ramload = 32'hC0DE; #1;
      chk("t5_addr300", bus.ramaddr, 32'h300);
      chk("t5_ihit", 32'(bus.ihit), 1);
      chk("t5_iload", bus.iload, 32'hC0DE);
      step();
      idle_inputs();

      // 6: halt blocks grants; halt mid-access lets it finish; reset drops access
      bus.halt = 1; bus.dREN = 1; bus.iREN = 1; bus.iaddr = 32'h400; bus.daddr = 32'h50;
      step(); step(); #1;
      chk("t6_halt_ramREN", 32'(bus.ramREN), 0);
      chk("t6_halt_ramWEN", 32'(bus.ramWEN), 0);
      bus.halt = 0;
      step();
      bus.halt = 1; #1;
      chk("t6_dacc_ramaddr", bus.ramaddr, 32'h50);
      bus.ram_ready = 1; bus.ramload = 32'h1111; #1;
      chk("t6_halt_midacc_dhit", 32'(bus.dhit), 1);
      step();
      bus.ram_ready = 0; bus.halt = 0; bus.iREN = 0;
      step(); #1;
      chk("t6_dacc2_ramREN", 32'(bus.ramREN), 1);
      nRST = 0; bus.ram_ready = 1; bus.ramload = 32'h2222; #1;
      chk("t6_rst_nodhit", 32'(bus.dhit), 0);
      step();
      bus.dREN = 0; #1;
      chk("t6_rst_ramREN", 32'(bus.ramREN), 0);
      chk("t6_rst_ramaddr", bus.ramaddr, 0);
      chk("t6_rst_dload", bus.dload, 0);
      nRST = 1; bus.ram_ready = 0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
